gate_table_arbiter: RTL and testbench
=====================================

Name: gate_table_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single gate_matrix_table (gate ROM loader) among NUM_REQ gate-application requesters.
- Accepts a 5-bit gate code per requester and drives the table's gate/ready inputs. Waits for the table's done_pulse, then acknowledges the winning requester, which samples the table's result array directly.
- Keeps a one-entry "last loaded gate" cache so that a repeated gate skips the 8-cycle reload. Includes a watchdog for a table that never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abort (≥ 16).
- CACHE_EN, 1, 1 enables the last-gate hit bypass; 0 forces every request to reload.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until ack.
- req_gate  in  NUM_REQ x 5  per-requester gate code; stable while req is high.
- cache_flush  in  1  one-cycle pulse; invalidates the cached gate.
- grant  out  NUM_REQ  one-hot owner of the table result; high from the cycle after arbitration through the ack cycle.
- ack  out  NUM_REQ  one-hot, one-cycle pulse; table result is valid and stable this cycle.
- err  out  1  one-cycle pulse on watchdog abort.
- err_id  out  $clog2(NUM_REQ)  index of the requester aborted by the most recent err.
- tbl_gate  out  5  to gate_matrix_table.gate.
- tbl_ready  out  1  to gate_matrix_table.ready; one-cycle pulse.
- tbl_done_pulse  in  1  from gate_matrix_table.done_pulse.

Behaviour:
- Reset (async):
  - state=IDLE; grant=0, ack=0, err=0, err_id=0, tbl_ready=0, tbl_gate=0.
  - rr_ptr=0; cache_valid=0; wdog=0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Search req starting at rr_ptr, wrapping modulo NUM_REQ. First set bit wins; latch win_id and win_gate.
  - On a hit (CACHE_EN && cache_valid && win_gate==cached_gate && !cache_flush), go to ACK.
  - Otherwise go to ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - grant[win_id]=1; tbl_gate=win_gate; tbl_ready=1 for exactly this cycle.
  - Clear wdog; go to WAIT.
- WAIT:
  - grant held; tbl_gate held at win_gate (the table addresses the ROM from gate on every load cycle).
  - Each cycle, wdog increments.
  - On tbl_done_pulse: cached_gate=win_gate, cache_valid=1, go to ACK.
  - Else if wdog==TIMEOUT_CYCLES-1: err=1, err_id=win_id, cache_valid=0, grant cleared, rr_ptr=win_id+1 (wrap), go to IDLE with no ack.
- ACK:
  - ack[win_id]=1 and grant[win_id]=1 for one cycle.
  - rr_ptr=win_id+1 (wrap); go to IDLE.
  - The requester must drop req in the cycle after ack, or it is re-arbitrated at lowest priority.
- Latency:
  - Miss: req seen at cycle T gives grant at T+1, tbl_ready at T+1, ack on the cycle after done_pulse (nominally T+12 with the current table).
  - Hit: ack at T+1, with no table access.
- Table spacing:
  - ACK→IDLE→ISSUE guarantees at least 2 cycles between done_pulse and the next tbl_ready, so the table has returned to its done state.
- tbl_done_pulse outside WAIT is ignored. It does not update the cache.
- A req that deasserts during ISSUE/WAIT does not abort the load. The load completes, the cache updates, and ack still pulses; the requester ignores it.
- cache_flush:
  - Clears cache_valid in any state.
  - If it coincides with done_pulse in WAIT, the flush wins and cache_valid=0.
- Simultaneous req from all requesters are served in order rr_ptr, rr_ptr+1, …; no requester is starved for more than NUM_REQ-1 grants.
- wdog width: $clog2(TIMEOUT_CYCLES); it saturates and does not wrap.

Decomposition:
- Shared package qc_pkg:
  - GATE_W=5.
  - state enum arb_state_t {IDLE, ISSUE, WAIT, ACK}.
  - function rr_pick(req, ptr) returning valid and index.
- One sub-module: rr_priority_pick, a combinational rotate–priority-encode–unrotate over NUM_REQ.
- Cache and watchdog registers stay in the top module.

Test Plan:
- Single miss: reset, then req[0]=1 with gate 5'd3 → tbl_ready at T+1 with tbl_gate=3; model done_pulse 10 cycles later → ack[0] on the next cycle, cache holds 3.
- Hit bypass: after the scenario above, req[1] with gate 3 → ack[1] at T+1, tbl_ready never asserts. Repeat with CACHE_EN=0 → full reload.
- Round-robin: req=4'b1111 held, gates 1,2,3,4 → ack order 0,1,2,3, then rr_ptr=0. With req[2] and req[0] only, starting at rr_ptr=1 → order 2,0.
- Watchdog: req[2] with gate 7 and no done_pulse → err with err_id=2 after TIMEOUT_CYCLES=64 WAIT cycles, no ack, cache invalid. A following request for gate 7 takes the miss path.
- Flush race: cache_flush coincident with done_pulse → ack issued, cache_valid=0. A following request for the same gate reloads.
- Async reset mid-WAIT: assert reset between clock edges → grant/tbl_ready clear immediately and cache is invalid. After release, a stray done_pulse is ignored and a new req arbitrates from rr_ptr=0.

Source files
------------

// File: rtl/qc_pkg.sv
// Shared types and helpers for the gate-table arbiter: gate width, FSM states
// and the round-robin pick used by rr_priority_pick.
package qc_pkg;

  localparam int GATE_W   = 5;
  localparam int PICK_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= PICK_MAX).
  function automatic rr_pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                       input logic [2:0]          ptr,
                                       input logic [3:0]          n);
    rr_pick_t   res;
    logic [3:0] k;
    res.valid = 1'b0;
    res.idx   = 3'd0;
    for (int i = 0; i < PICK_MAX; i++) begin
      k = {1'b0, ptr} + 4'(i);
      if (k >= n) begin
        k = k - n;
      end
      if (!res.valid && (4'(i) < n) && req[k[2:0]]) begin
        res.valid = 1'b1;
        res.idx   = k[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: rotate by the pointer, take the first
// requester, map back to an absolute index.
module rr_priority_pick
  import qc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  rr_pick_t w_pick;

  // Priority search starting at the round-robin pointer.
  always_comb begin
    w_pick = rr_pick(PICK_MAX'(i_req), 3'(i_ptr), 4'(NUM_REQ));
  end

  assign o_valid = w_pick.valid;
  assign o_idx   = IDX_W'(w_pick.idx);

endmodule

// File: rtl/gate_table_arbiter.sv
// Round-robin arbiter sharing one gate_matrix_table among NUM_REQ requesters,
// with a one-entry last-gate cache and a watchdog on the table's completion.
module gate_table_arbiter
  import qc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][GATE_W-1:0]  req_gate,
  input  logic                            cache_flush,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            err,
  output logic [$clog2(NUM_REQ)-1:0]      err_id,
  output logic [GATE_W-1:0]               tbl_gate,
  output logic                            tbl_ready,
  input  logic                            tbl_done_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]    WD_MAX  = {WD_W{1'b1}};
  localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_win_id;
  logic [GATE_W-1:0]   r_win_gate;
  logic [GATE_W-1:0]   r_cached_gate;
  logic                r_cache_valid;
  logic [WD_W-1:0]     r_wdog;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_err;
  logic [IDX_W-1:0]    r_err_id;
  logic [GATE_W-1:0]   r_tbl_gate;
  logic                r_tbl_ready;

  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [GATE_W-1:0]   w_sel_gate;
  logic                w_hit;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [IDX_W-1:0]    w_next_ptr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Winner gate, cache-hit test, one-hot masks and the wrapped next pointer.
  always_comb begin
    w_sel_gate = req_gate[w_pick_idx];
    w_hit      = CACHE_EN && r_cache_valid && (w_sel_gate == r_cached_gate) && !cache_flush;
    w_pick_oh  = REQ_ONE << w_pick_idx;
    w_win_oh   = REQ_ONE << r_win_id;
    if (r_win_id == IDX_W'(NUM_REQ - 1)) begin
      w_next_ptr = {IDX_W{1'b0}};
    end else begin
      w_next_ptr = r_win_id + IDX_W'(1);
    end
  end

  // Sequencer FSM with registered outputs, cache and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= {IDX_W{1'b0}};
      r_win_id      <= {IDX_W{1'b0}};
      r_win_gate    <= {GATE_W{1'b0}};
      r_cached_gate <= {GATE_W{1'b0}};
      r_cache_valid <= 1'b0;
      r_wdog        <= {WD_W{1'b0}};
      r_grant       <= {NUM_REQ{1'b0}};
      r_ack         <= {NUM_REQ{1'b0}};
      r_err         <= 1'b0;
      r_err_id      <= {IDX_W{1'b0}};
      r_tbl_gate    <= {GATE_W{1'b0}};
      r_tbl_ready   <= 1'b0;
    end else begin
      r_ack       <= {NUM_REQ{1'b0}};
      r_err       <= 1'b0;
      r_tbl_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_win_id   <= w_pick_idx;
            r_win_gate <= w_sel_gate;
            r_grant    <= w_pick_oh;
            if (w_hit) begin
              r_ack   <= w_pick_oh;
              r_state <= ACK;
            end else begin
              r_tbl_gate  <= w_sel_gate;
              r_tbl_ready <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_wdog  <= {WD_W{1'b0}};
          r_state <= WAIT;
        end
        WAIT: begin
          // Completion beats a same-cycle timeout.
          if (tbl_done_pulse) begin
            r_cached_gate <= r_win_gate;
            r_cache_valid <= 1'b1;
            r_ack         <= w_win_oh;
            r_state       <= ACK;
          end else if (r_wdog == WD_LAST) begin
            r_err         <= 1'b1;
            r_err_id      <= r_win_id;
            r_cache_valid <= 1'b0;
            r_grant       <= {NUM_REQ{1'b0}};
            r_rr_ptr      <= w_next_ptr;
            r_state       <= IDLE;
          end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ACK: begin
          r_grant  <= {NUM_REQ{1'b0}};
          r_rr_ptr <= w_next_ptr;
          r_state  <= IDLE;
        end
        default: begin
          r_grant <= {NUM_REQ{1'b0}};
          r_state <= IDLE;
        end
      endcase
      // Flush overrides any cache fill in the same cycle.
      if (cache_flush) begin
        r_cache_valid <= 1'b0;
      end
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign err       = r_err;
  assign err_id    = r_err_id;
  assign tbl_gate  = r_tbl_gate;
  assign tbl_ready = r_tbl_ready;

endmodule

// File: tb/tb_gate_table_arbiter.sv
// Randomized bench for gate_table_arbiter: requester and table behaviour are
// randomized; a transaction-level reference model predicts every output.
module tb_gate_table_arbiter;
  import qc_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 64;
  localparam bit CACHE_EN = 1'b1;
  localparam int N_CYC    = 4000;
  localparam int BIG      = 32'h3fff_ffff;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][GATE_W-1:0] req_gate;
  logic                           cache_flush;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             ack;
  logic                           err;
  logic [1:0]                     err_id;
  logic [GATE_W-1:0]              tbl_gate;
  logic                           tbl_ready;
  logic                           tbl_done_pulse;

  gate_table_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CACHE_EN       (CACHE_EN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_gate       (req_gate),
    .cache_flush    (cache_flush),
    .grant          (grant),
    .ack            (ack),
    .err            (err),
    .err_id         (err_id),
    .tbl_gate       (tbl_gate),
    .tbl_ready      (tbl_ready),
    .tbl_done_pulse (tbl_done_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: one in-flight transaction described by its cycle numbers.
  bit m_active, m_hit, m_open, m_valid;
  int m_rr, m_cached, m_win, m_gate, m_t0, m_end, m_done_cyc;
  int m_err_cyc, m_err_id, m_tbl_gate;

  bit pend [NUM_REQ];
  int gsel [NUM_REQ];
  int tbl_due;
  bit did_reset, force_stray;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_hit = 1'b0; m_open = 1'b0; m_valid = 1'b0;
    m_rr = 0; m_cached = 0; m_win = 0; m_gate = 0; m_t0 = 0; m_end = 0;
    m_done_cyc = -1; m_err_cyc = -1; m_err_id = 0; m_tbl_gate = 0;
    tbl_due = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      gsel[i] = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NUM_REQ-1:0] eg, ea;
    bit busy;
    busy = m_active && (cyc >= m_t0 + 1) && (cyc <= m_end);
    eg = '0;
    ea = '0;
    if (busy) eg[m_win] = 1'b1;
    if (busy && ((m_hit && cyc == m_t0 + 1) || (!m_hit && m_done_cyc >= 0 && cyc == m_done_cyc + 1)))
      ea[m_win] = 1'b1;
    check("grant",     32'(grant),     32'(eg));
    check("ack",       32'(ack),       32'(ea));
    check("tbl_ready", 32'(tbl_ready), 32'(m_active && !m_hit && cyc == m_t0 + 1));
    check("err",       32'(err),       32'(cyc == m_err_cyc));
    check("err_id",    32'(err_id),    32'(m_err_id));
    check("tbl_gate",  32'(tbl_gate),  32'(m_tbl_gate));
  endtask

  function automatic int pick_gate();
    int r;
    r = int'($urandom_range(3, 0));
    case (r)
      0: return 3;
      1: return 7;
      2: return 12;
      default: return int'($urandom_range(31, 0));
    endcase
  endfunction

  task automatic drive_inputs();
    bit done, in_wait, flush;
    int r;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) pend[i] = 1'b0;
      else if (pend[i] && $urandom_range(63, 0) == 0) pend[i] = 1'b0;
      else if (!pend[i] && $urandom_range(3, 0) == 0) begin
        pend[i] = 1'b1;
        gsel[i] = pick_gate();
      end
    end
    if (tbl_ready) begin
      r = int'($urandom_range(7, 0));
      if (r == 0)      tbl_due = -1;
      else if (r == 1) tbl_due = cyc + int'($urandom_range(20, 1));
      else             tbl_due = cyc + 10;
    end
    done = (tbl_due >= 0) && (cyc == tbl_due);
    if (done) tbl_due = -1;
    in_wait = m_open && (cyc >= m_t0 + 2);
    if (!in_wait && (force_stray || $urandom_range(15, 0) == 0)) done = 1'b1;
    force_stray = 1'b0;
    flush = ($urandom_range(31, 0) == 0) || (done && in_wait && $urandom_range(3, 0) == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]      = pend[i];
      req_gate[i] = 5'(gsel[i]);
    end
    cache_flush    = flush;
    tbl_done_pulse = done;
  endtask

  task automatic model_step();
    int w, idx;
    if (m_open && cyc >= m_t0 + 2) begin
      if (tbl_done_pulse) begin
        m_open = 1'b0; m_done_cyc = cyc; m_end = cyc + 1;
        m_cached = m_gate; m_valid = 1'b1;
      end else if (cyc == m_t0 + TIMEOUT + 1) begin
        m_open = 1'b0; m_end = cyc; m_err_cyc = cyc + 1;
        m_err_id = m_win; m_valid = 1'b0;
      end
    end
    if ((!m_active || cyc > m_end) && req != '0) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_rr + k) % NUM_REQ;
        if (w < 0 && req[idx]) w = idx;
      end
      m_active = 1'b1; m_win = w; m_gate = int'(req_gate[w]); m_t0 = cyc;
      m_done_cyc = -1; m_rr = (w + 1) % NUM_REQ;
      m_hit = CACHE_EN && m_valid && (m_gate == m_cached) && !cache_flush;
      if (m_hit) m_end = cyc + 1;
      else begin
        m_end = BIG; m_open = 1'b1; m_tbl_gate = m_gate;
      end
    end
    if (cache_flush) m_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_gate = '0; cache_flush = 1'b0; tbl_done_pulse = 1'b0;
    did_reset = 1'b0; force_stray = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    for (int k = 0; k < N_CYC; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      if (reset) begin
        reset = 1'b0;
        force_stray = 1'b1;
      end
      drive_inputs();
      model_step();
      if (!did_reset && cyc > 2000 && m_open && cyc >= m_t0 + 3) begin
        #2 reset = 1'b1;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_tbl_ready", 32'(tbl_ready), 32'd0);
        did_reset = 1'b1;
        model_reset();
        req = '0; cache_flush = 1'b0; tbl_done_pulse = 1'b0;
      end
    end
    check("mid_wait_reset_done", 32'(did_reset), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
